// File: rtl/mul_div_unit_if.sv
// Request/response bundle for mul_div_unit: valid/ready on the operand side and on the result side.
// The pipeline drives the master modport and the unit takes the slave modport.
interface mul_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output in_valid, op, src1, src2, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, src1, src2, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 RISC-V M-extension multiply/divide unit, one operation per WIDTH cycles.
// Define MDU_FAST_PATH_EN to finish divide-by-zero, signed overflow and zero multiplies in one cycle.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  mul_div_unit_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

`ifdef MDU_FAST_PATH_EN
  localparam bit FastPath = 1'b1;
`else
  localparam bit FastPath = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               msub_q, msub_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               spec_q, spec_d;
  logic [WIDTH-1:0]   spec_res_q, spec_res_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;

  // Operand decode, only meaningful while idle
  logic             in_div, in_rem, in_div_signed, in_signed_a, in_signed_b;
  logic             src1_neg, src2_neg, div_zero, div_ovf, mul_zero;
  logic [WIDTH-1:0] src1_mag, src2_mag, min_neg, in_spec_res;

  always_comb begin
    in_div        = bus.op[2];
    in_rem        = bus.op[1];
    in_div_signed = ~bus.op[0];
    in_signed_a   = (bus.op[1:0] == 2'b01) || (bus.op[1:0] == 2'b10);
    in_signed_b   = (bus.op[1:0] == 2'b01);
    src1_neg      = in_div_signed & bus.src1[WIDTH-1];
    src2_neg      = in_div_signed & bus.src2[WIDTH-1];
    src1_mag      = src1_neg ? -bus.src1 : bus.src1;
    src2_mag      = src2_neg ? -bus.src2 : bus.src2;
    min_neg       = {1'b1, {(WIDTH-1){1'b0}}};
    div_zero      = in_div && (bus.src2 == '0);
    div_ovf       = in_div && in_div_signed && (bus.src1 == min_neg) && (bus.src2 == '1);
    mul_zero      = !in_div && ((bus.src1 == '0) || (bus.src2 == '0));
    if (div_zero) begin
      in_spec_res = in_rem ? bus.src1 : '1;
    end else if (div_ovf) begin
      in_spec_res = in_rem ? '0 : bus.src1;
    end else begin
      in_spec_res = '0;
    end
  end

  // One iteration of the datapath plus the sign-fixed final result
  logic               last;
  logic [WIDTH:0]     rem_shift, rem_diff;
  logic               qbit;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   quot, rmd, fin_res;

  always_comb begin
    last      = (cnt_q == CntLast);
    rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, mcand_q[WIDTH-1:0]};
    qbit      = ~rem_diff[WIDTH];
    if (op_q[2]) begin
      acc_step = {(qbit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], qbit};
    end else if (mplier_q[0]) begin
      // The top bit of a signed multiplier carries negative weight
      acc_step = (last && msub_q) ? (acc_q - mcand_q) : (acc_q + mcand_q);
    end else begin
      acc_step = acc_q;
    end
    quot = acc_step[WIDTH-1:0];
    rmd  = acc_step[2*WIDTH-1:WIDTH];
    if (spec_q) begin
      fin_res = spec_res_q;
    end else if (op_q[2]) begin
      if (op_q[1]) begin
        fin_res = rneg_q ? -rmd : rmd;
      end else begin
        fin_res = qneg_q ? -quot : quot;
      end
    end else begin
      fin_res = (op_q[1:0] == 2'b00) ? quot : rmd;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    msub_d      = msub_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    spec_d      = spec_q;
    spec_res_d  = spec_res_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;

    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          state_d    = StBusy;
          cnt_d      = '0;
          op_d       = bus.op;
          spec_d     = div_zero || div_ovf || (FastPath && mul_zero);
          spec_res_d = in_spec_res;
          qneg_d     = src1_neg ^ src2_neg;
          rneg_d     = src1_neg;
          msub_d     = in_signed_b;
          if (in_div) begin
            acc_d    = {{WIDTH{1'b0}}, src1_mag};
            mcand_d  = {{WIDTH{1'b0}}, src2_mag};
            mplier_d = '0;
          end else begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{in_signed_a & bus.src1[WIDTH-1]}}, bus.src1};
            mplier_d = bus.src2;
          end
        end
      end
      StBusy: begin
        acc_d = acc_step;
        if (!op_q[2]) begin
          mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        end
        if (last || (FastPath && spec_q)) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          result_d    = fin_res;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      msub_q      <= 1'b0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      spec_q      <= 1'b0;
      spec_res_q  <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      msub_q      <= msub_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      spec_q      <= spec_d;
      spec_res_q  <= spec_res_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit (WIDTH 32): results, latency, backpressure and reset.
// Special-case latency expectations follow MDU_FAST_PATH_EN.
module tb_mul_div_unit;

  localparam int unsigned W = 32;

`ifdef MDU_FAST_PATH_EN
  localparam int FastLat = 1;
`else
  localparam int FastLat = W;
`endif

  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpMulhu  = 3'b011;
  localparam logic [2:0] OpDiv    = 3'b100;
  localparam logic [2:0] OpDivu   = 3'b101;
  localparam logic [2:0] OpRem    = 3'b110;
  localparam logic [2:0] OpRemu   = 3'b111;

  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Counts edges after accept until out_valid; lat stays 0 if the bound expires
  task automatic wait_valid(input string tag, output int lat);
    bit rdy_seen;
    rdy_seen = 1'b0;
    lat      = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
      if (bus.in_ready) rdy_seen = 1'b1;
    end
    check_eq({tag, "_busy_rdy"}, 32'(rdy_seen), 32'd0);
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    bus.op       = op;
    bus.src1     = a;
    bus.src2     = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op       = ~op;
    bus.src1     = ~a;
    bus.src2     = ~b;
    check_eq({tag, "_acc_rdy"}, 32'(bus.in_ready), 32'd0);
    wait_valid(tag, lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_res"}, bus.result, exp);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_eq({tag, "_hs_vld"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, "_hs_rdy"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = '0;
    bus.src1      = '0;
    bus.src2      = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rdy", 32'(bus.in_ready), 32'd1);
    check_eq("rst_vld", 32'(bus.out_valid), 32'd0);
    check_eq("rst_res", bus.result, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_op("mul",       OpMul,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, W);
    do_op("mulh",      OpMulh,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, W);
    do_op("mulhu",     OpMulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, W);
    do_op("mulhsu",    OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, W);
    do_op("mul_zero",  OpMul,    32'd0,          32'd5,         32'd0,         FastLat);
    do_op("div",       OpDiv,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, W);
    do_op("rem",       OpRem,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, W);
    do_op("divu",      OpDivu,   32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, W);
    do_op("remu",      OpRemu,   32'hFFFF_FFFF, 32'h10,        32'h0000_000F, W);
    do_op("div_nn",    OpDiv,    32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'd6,         W);
    do_op("rem_nn",    OpRem,    32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'hFFFF_FFFE, W);
    do_op("rem_pn",    OpRem,    32'd20,         32'hFFFF_FFFD, 32'd2,         W);
    do_op("div_z",     OpDiv,    32'd5,          32'd0,         32'hFFFF_FFFF, FastLat);
    do_op("rem_z",     OpRem,    32'd5,          32'd0,         32'd5,         FastLat);
    do_op("divu_z",    OpDivu,   32'd5,          32'd0,         32'hFFFF_FFFF, FastLat);
    do_op("remu_z",    OpRemu,   32'd5,          32'd0,         32'd5,         FastLat);
    do_op("div_ovf",   OpDiv,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FastLat);
    do_op("rem_ovf",   OpRem,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         FastLat);
    do_op("divu_big",  OpDivu,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         W);
    do_op("remu_big",  OpRemu,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, W);

    // Backpressure, then back-to-back accept right after the handshake
    bus.op       = OpDivu;
    bus.src1     = 32'd100;
    bus.src2     = 32'd7;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_valid("bp", lat);
    check_eq("bp_lat", 32'(lat), 32'(W));
    check_eq("bp_res", bus.result, 32'd14);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp_hold_res", bus.result, 32'd14);
      check_eq("bp_hold_vld", 32'(bus.out_valid), 32'd1);
      check_eq("bp_hold_rdy", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    bus.op        = OpMul;
    bus.src1      = 32'd6;
    bus.src2      = 32'd7;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bp_rel_vld", 32'(bus.out_valid), 32'd0);
    check_eq("bp_rel_rdy", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_eq("b2b_acc_rdy", 32'(bus.in_ready), 32'd0);
    wait_valid("b2b", lat);
    check_eq("b2b_lat", 32'(lat), 32'(W));
    check_eq("b2b_res", bus.result, 32'd42);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_eq("b2b_hs_rdy", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of a divide
    bus.op       = OpDivu;
    bus.src1     = 32'd1000;
    bus.src2     = 32'd3;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mrst_vld", 32'(bus.out_valid), 32'd0);
    check_eq("mrst_res", bus.result, 32'd0);
    check_eq("mrst_rdy", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_eq("mrst_quiet", 32'(bus.out_valid), 32'd0);
    do_op("mul_after_rst", OpMul, 32'd3, 32'd4, 32'd12, W);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
